// File: rtl/decode_queue.sv
// rtl/decode_queue.sv - instruction queue between fetch and decode with a registered, pre-decoded ID slot
module decode_queue #(
    parameter int DEPTH = 4,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             f_valid,
    output logic             f_ready,
    input  logic [31:0]      f_pc,
    input  logic [31:0]      f_instr,
    input  logic             d_stall,
    input  logic             flush,
    output logic             d_valid,
    output logic [31:0]      d_pc,
    output logic [31:0]      d_instr,
    output logic [4:0]       d_rs,
    output logic [4:0]       d_rt,
    output logic [4:0]       d_rd,
    output logic [31:0]      d_imm,
    output logic [1:0]       d_rs_tuse,
    output logic [1:0]       d_rt_tuse,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [31:0]      pc_mem    [DEPTH];
    logic [31:0]      instr_mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             push;
    logic             pop;
    logic             advance;

    logic [31:0]      head_instr;
    logic [5:0]       opcode;
    logic [5:0]       funct;
    logic [31:0]      pre_imm;
    logic [1:0]       pre_rs_tuse;
    logic [1:0]       pre_rt_tuse;

    // No pop credit: a full queue refuses fetch even when the slot drains this cycle.
    assign f_ready = (count < CNT_W'(DEPTH));
    assign push    = f_valid & f_ready & ~flush;
    assign advance = ~d_valid | ~d_stall;
    assign pop     = (count != '0) & advance & ~flush;

    assign head_instr = instr_mem[rd_ptr];
    assign opcode     = head_instr[31:26];
    assign funct      = head_instr[5:0];

    always_comb begin
        pre_imm     = 32'd0;
        pre_rs_tuse = 2'd3;
        pre_rt_tuse = 2'd3;
        case (opcode)
            6'h00: begin
                case (funct)
                    6'h20, 6'h22: begin
                        pre_rs_tuse = 2'd1;
                        pre_rt_tuse = 2'd1;
                    end
                    6'h08: pre_rs_tuse = 2'd0;
                    default: ;
                endcase
            end
            6'h0D: begin
                pre_imm     = {16'd0, head_instr[15:0]};
                pre_rs_tuse = 2'd1;
            end
            6'h23: begin
                pre_imm     = {{16{head_instr[15]}}, head_instr[15:0]};
                pre_rs_tuse = 2'd1;
            end
            6'h2B: begin
                pre_imm     = {{16{head_instr[15]}}, head_instr[15:0]};
                pre_rs_tuse = 2'd1;
                pre_rt_tuse = 2'd2;
            end
            6'h04: begin
                pre_imm     = {{14{head_instr[15]}}, head_instr[15:0], 2'b00};
                pre_rs_tuse = 2'd0;
                pre_rt_tuse = 2'd0;
            end
            6'h0F: pre_imm = {head_instr[15:0], 16'd0};
            default: ;
        endcase
    end

    // Queue storage carries no reset; its contents are only read behind count.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[wr_ptr]    <= f_pc;
            instr_mem[wr_ptr] <= f_instr;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            d_valid   <= 1'b0;
            d_pc      <= 32'd0;
            d_instr   <= 32'd0;
            d_rs      <= 5'd0;
            d_rt      <= 5'd0;
            d_rd      <= 5'd0;
            d_imm     <= 32'd0;
            d_rs_tuse <= 2'd0;
            d_rt_tuse <= 2'd0;
        end else if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            d_valid <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr    <= rd_ptr + PTR_W'(1);
                d_valid   <= 1'b1;
                d_pc      <= pc_mem[rd_ptr];
                d_instr   <= head_instr;
                d_rs      <= head_instr[25:21];
                d_rt      <= head_instr[20:16];
                d_rd      <= head_instr[15:11];
                d_imm     <= pre_imm;
                d_rs_tuse <= pre_rs_tuse;
                d_rt_tuse <= pre_rt_tuse;
            end else if (advance) begin
                d_valid <= 1'b0;
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_decode_queue.sv
// tb/tb_decode_queue.sv - randomized bench for decode_queue against a queue-based reference model
module tb_decode_queue;

    localparam int DEPTH = 4;
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             f_valid = 1'b0;
    logic             f_ready;
    logic [31:0]      f_pc = 32'd0;
    logic [31:0]      f_instr = 32'd0;
    logic             d_stall = 1'b0;
    logic             flush = 1'b0;
    logic             d_valid;
    logic [31:0]      d_pc;
    logic [31:0]      d_instr;
    logic [4:0]       d_rs;
    logic [4:0]       d_rt;
    logic [4:0]       d_rd;
    logic [31:0]      d_imm;
    logic [1:0]       d_rs_tuse;
    logic [1:0]       d_rt_tuse;
    logic [CNT_W-1:0] count;

    decode_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .f_valid(f_valid), .f_ready(f_ready), .f_pc(f_pc), .f_instr(f_instr),
        .d_stall(d_stall), .flush(flush),
        .d_valid(d_valid), .d_pc(d_pc), .d_instr(d_instr),
        .d_rs(d_rs), .d_rt(d_rt), .d_rd(d_rd), .d_imm(d_imm),
        .d_rs_tuse(d_rs_tuse), .d_rt_tuse(d_rt_tuse), .count(count)
    );

    always #5 clk = ~clk;

    int vecs = 0;
    int errs = 0;

    // Reference model: a plain queue of {pc, instr} plus the expected ID slot contents.
    logic [63:0] mq[$];
    logic        e_valid;
    logic [31:0] e_pc, e_instr, e_imm;
    logic [1:0]  e_rs_tuse, e_rt_tuse;
    bit          m_pushed, m_popped;

    function automatic logic [35:0] decode_ref(input logic [31:0] ins);
        int signed simm;
        simm = $signed(ins[15:0]);
        case (ins[31:26])
            6'h00: case (ins[5:0])
                6'h20, 6'h22: return {32'd0, 2'd1, 2'd1};
                6'h08:        return {32'd0, 2'd0, 2'd3};
                default:      return {32'd0, 2'd3, 2'd3};
            endcase
            6'h0D:   return {32'(ins[15:0]), 2'd1, 2'd3};
            6'h23:   return {32'(simm), 2'd1, 2'd3};
            6'h2B:   return {32'(simm), 2'd1, 2'd2};
            6'h04:   return {32'(simm * 4), 2'd0, 2'd0};
            6'h0F:   return {32'(ins[15:0]) * 32'd65536, 2'd3, 2'd3};
            default: return {32'd0, 2'd3, 2'd3};
        endcase
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        logic [5:0]  ops [8];
        logic [5:0]  fns [4];
        ops = '{6'h00, 6'h0D, 6'h23, 6'h2B, 6'h04, 6'h0F, 6'h03, 6'h3F};
        fns = '{6'h20, 6'h22, 6'h08, 6'h2A};
        r = $urandom;
        r[31:26] = ops[$urandom_range(0, 7)];
        if (r[31:26] == 6'h00) r[5:0] = fns[$urandom_range(0, 3)];
        return r;
    endfunction

    task automatic model_clear();
        mq.delete();
        e_valid = 0; e_pc = 0; e_instr = 0; e_imm = 0; e_rs_tuse = 0; e_rt_tuse = 0;
    endtask

    // Advance the model by the edge that follows, then sample 1 time unit after that edge.
    task automatic tick();
        bit adv, pop, push;
        logic [63:0] e;
        m_pushed = 0; m_popped = 0;
        if (flush) begin
            mq.delete();
            e_valid = 0;
        end else begin
            adv  = !e_valid || !d_stall;
            pop  = (mq.size() != 0) && adv;
            push = f_valid && (mq.size() < DEPTH);
            if (pop) begin
                e = mq.pop_front();
                e_valid = 1; e_pc = e[63:32]; e_instr = e[31:0];
                {e_imm, e_rs_tuse, e_rt_tuse} = decode_ref(e_instr);
            end else if (adv) begin
                e_valid = 0;
            end
            if (push) mq.push_back({f_pc, f_instr});
            m_pushed = push; m_popped = pop;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1; f_valid = 0; d_stall = 0; flush = 0;
        @(posedge clk); #1;
        reset = 0;
        model_clear();
    endtask

    task automatic test_reset();
        reset = 1; #3;
        vecs++;
        if ({d_valid, d_pc, d_instr, d_imm, d_rs_tuse, d_rt_tuse, count, f_ready} !== {1'b0, 96'd0, 4'd0, CNT_W'(0), 1'b1}) begin
            errs++; $display("FAIL reset_state: got v=%b pc=%h cnt=%0d rdy=%b, want v=0 pc=0 cnt=0 rdy=1", d_valid, d_pc, count, f_ready);
        end
        do_reset();
    endtask

    task automatic test_lw_latency();
        f_valid = 1; f_pc = 32'h3000; f_instr = 32'h8D28FFFC;
        tick();
        f_valid = 0;
        vecs++;
        if ({d_valid, count} !== {1'b0, CNT_W'(1)}) begin
            errs++; $display("FAIL lw_first_edge: got v=%b cnt=%0d, want v=0 cnt=1", d_valid, count);
        end
        tick();
        vecs++;
        if ({d_valid, d_pc, d_rs, d_rt, d_imm, d_rs_tuse, d_rt_tuse} !== {1'b1, 32'h3000, 5'd9, 5'd8, 32'hFFFFFFFC, 2'd1, 2'd3}) begin
            errs++; $display("FAIL lw_slot: got v=%b pc=%h rs=%0d rt=%0d imm=%h tu=%0d/%0d, want 1 3000 9 8 fffffffc 1/3", d_valid, d_pc, d_rs, d_rt, d_imm, d_rs_tuse, d_rt_tuse);
        end
    endtask

    task automatic test_stall_full();
        d_stall = 1;
        for (int i = 0; i < DEPTH; i++) begin
            f_valid = 1; f_pc = 32'h5000 + 32'(i * 4); f_instr = rand_instr();
            tick();
        end
        f_pc = 32'h6000; f_instr = 32'h00000020;
        vecs++;
        if ({count, f_ready, d_valid, d_pc} !== {CNT_W'(DEPTH), 1'b0, 1'b1, 32'h3000}) begin
            errs++; $display("FAIL full_stalled: got cnt=%0d rdy=%b v=%b pc=%h, want cnt=4 rdy=0 v=1 pc=3000", count, f_ready, d_valid, d_pc);
        end
        tick();
        vecs++;
        if ({count, d_pc, d_imm} !== {CNT_W'(DEPTH), 32'h3000, 32'hFFFFFFFC}) begin
            errs++; $display("FAIL fifth_refused: got cnt=%0d pc=%h imm=%h, want cnt=4 pc=3000 imm=fffffffc", count, d_pc, d_imm);
        end
        f_valid = 0; d_stall = 0;
        for (int i = 0; i < DEPTH; i++) begin
            tick();
            vecs++;
            if ({d_valid, d_pc, count} !== {1'b1, 32'h5000 + 32'(i * 4), CNT_W'(DEPTH - 1 - i)}) begin
                errs++; $display("FAIL drain_%0d: got v=%b pc=%h cnt=%0d, want v=1 pc=%h cnt=%0d", i, d_valid, d_pc, count, 32'h5000 + 32'(i * 4), DEPTH - 1 - i);
            end
        end
        tick();
        vecs++;
        if (d_valid !== 1'b0 || d_pc !== 32'h500C) begin
            errs++; $display("FAIL drain_empty: got v=%b pc=%h, want v=0 pc=0000500c", d_valid, d_pc);
        end
    endtask

    task automatic test_flush();
        d_stall = 1;
        f_valid = 1; f_pc = 32'h7000; f_instr = 32'h00000020; tick();
        f_pc = 32'h7004; tick();
        f_pc = 32'h7008; tick();
        vecs++;
        if (count !== CNT_W'(2)) begin
            errs++; $display("FAIL flush_setup: got cnt=%0d, want 2", count);
        end
        flush = 1; f_pc = 32'h700C;
        tick();
        vecs++;
        if ({count, d_valid, f_ready} !== {CNT_W'(0), 1'b0, 1'b1}) begin
            errs++; $display("FAIL flush_clear: got cnt=%0d v=%b rdy=%b, want 0 0 1", count, d_valid, f_ready);
        end
        flush = 0; f_valid = 0; d_stall = 0;
        tick();
        vecs++;
        if ({count, d_valid} !== {CNT_W'(0), 1'b0}) begin
            errs++; $display("FAIL flush_drop: got cnt=%0d v=%b, want 0 0", count, d_valid);
        end
    endtask

    task automatic test_beq_lui();
        f_valid = 1; f_pc = 32'h8000; f_instr = 32'h1022FFFF; tick();
        f_pc = 32'h8004; f_instr = 32'h3C031234; tick();
        f_valid = 0;
        vecs++;
        if ({d_pc, d_imm, d_rs_tuse, d_rt_tuse} !== {32'h8000, 32'hFFFFFFFC, 2'd0, 2'd0}) begin
            errs++; $display("FAIL beq_decode: got pc=%h imm=%h tu=%0d/%0d, want 8000 fffffffc 0/0", d_pc, d_imm, d_rs_tuse, d_rt_tuse);
        end
        tick();
        vecs++;
        if ({d_pc, d_rt, d_imm, d_rs_tuse, d_rt_tuse} !== {32'h8004, 5'd3, 32'h12340000, 2'd3, 2'd3}) begin
            errs++; $display("FAIL lui_decode: got pc=%h rt=%0d imm=%h tu=%0d/%0d, want 8004 3 12340000 3/3", d_pc, d_rt, d_imm, d_rs_tuse, d_rt_tuse);
        end
        tick();
    endtask

    task automatic test_stream(input int n_pc, input int max_cycles, input int flush_pct);
        int sent = 0, seen = 0, cyc = 0, max_cnt = 0;
        do_reset();
        while (seen < n_pc && cyc < max_cycles) begin
            f_valid = (sent < n_pc) && ($urandom_range(0, 3) != 0);
            f_pc    = 32'h4000 + 32'(sent * 4);
            f_instr = rand_instr();
            d_stall = ($urandom_range(0, 2) == 0);
            flush   = ($urandom_range(0, 99) < flush_pct);
            tick();
            cyc++;
            if (flush) begin
                // Flush discards everything not yet in the slot; refetch from the first lost PC.
                sent = seen;
                flush = 0;
            end else begin
                if (m_pushed) sent++;
                if (m_popped) begin
                    vecs++;
                    if (d_pc !== 32'h4000 + 32'(seen * 4)) begin
                        errs++; $display("FAIL stream_order: got pc=%h, want %h", d_pc, 32'h4000 + 32'(seen * 4));
                    end
                    seen++;
                end
            end
            if (int'(count) > max_cnt) max_cnt = int'(count);
            vecs++;
            if ({d_valid, d_pc, d_instr, d_rs, d_rt, d_rd, d_imm, d_rs_tuse, d_rt_tuse, count, f_ready}
                !== {e_valid, e_pc, e_instr, e_instr[25:21], e_instr[20:16], e_instr[15:11], e_imm, e_rs_tuse, e_rt_tuse,
                     CNT_W'(mq.size()), 1'(mq.size() < DEPTH)}) begin
                errs++; $display("FAIL stream_model cyc=%0d: got v=%b pc=%h ins=%h imm=%h tu=%0d/%0d cnt=%0d, want v=%b pc=%h ins=%h imm=%h tu=%0d/%0d cnt=%0d",
                    cyc, d_valid, d_pc, d_instr, d_imm, d_rs_tuse, d_rt_tuse, count, e_valid, e_pc, e_instr, e_imm, e_rs_tuse, e_rt_tuse, mq.size());
            end
        end
        d_stall = 0; f_valid = 0;
        vecs++;
        if (seen != n_pc || max_cnt > DEPTH) begin
            errs++; $display("FAIL stream_done: got seen=%0d max_cnt=%0d, want seen=%0d max_cnt<=%0d", seen, max_cnt, n_pc, DEPTH);
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        f_valid = 1; f_instr = 32'h00000022;
        f_pc = 32'h9000; tick();
        f_pc = 32'h9004; tick();
        d_stall = 1;
        f_pc = 32'h9008; tick();
        f_pc = 32'h900C; tick();
        f_valid = 0;
        vecs++;
        if ({d_valid, count} !== {1'b1, CNT_W'(3)}) begin
            errs++; $display("FAIL async_setup: got v=%b cnt=%0d, want v=1 cnt=3", d_valid, count);
        end
        #2 reset = 1;
        #1;
        vecs++;
        if ({d_valid, count, d_pc, f_ready} !== {1'b0, CNT_W'(0), 32'd0, 1'b1}) begin
            errs++; $display("FAIL async_reset: got v=%b cnt=%0d pc=%h rdy=%b, want 0 0 0 1", d_valid, count, d_pc, f_ready);
        end
        @(posedge clk); #1;
        reset = 0; d_stall = 0;
        model_clear();
    endtask

    initial begin
        model_clear();
        test_reset();
        test_lw_latency();
        test_stall_full();
        test_flush();
        test_beq_lui();
        test_stream(10, 200, 0);
        test_stream(60, 2000, 4);
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule

// File: doc/decode_queue.md
# decode_queue

Parametrised ID stage front end for the pipelined MIPS core. It holds a DEPTH-entry instruction queue between fetch and decode, using a valid/ready handshake on the fetch side. The ID pipeline slot is registered and carries pre-decoded fields: register addresses, extended immediate, and rs/rt Tuse. That slot honours the hazard unit's stall and the branch unit's flush. It replaces the bare IF/ID register plus combinational field split.

## Interface
Parameters:
- DEPTH, 4, queue entries; power of two, ≥2
- CNT_W, $clog2(DEPTH+1), width of occupancy count

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-high; clears all state immediately
- f_valid  in  1  fetch presents an instruction
- f_ready  out  1  queue can accept; = (count < DEPTH)
- f_pc  in  32  PC of presented instruction
- f_instr  in  32  presented instruction word
- d_stall  in  1  hazard unit: hold ID slot
- flush  in  1  redirect: discard queue and ID slot
- d_valid  out  1  ID slot holds a live instruction
- d_pc, d_instr  out  32 each  slot PC / instruction
- d_rs, d_rt, d_rd  out  5 each  instr[25:21], [20:16], [15:11]
- d_imm  out  32  extended immediate (see Operation)
- d_rs_tuse, d_rt_tuse  out  2 each  Tuse; 3 = operand unused
- count  out  CNT_W  queue occupancy

## Operation
- Push = f_valid & f_ready & ~flush. The entry is written at wr_ptr, and wr_ptr increments modulo DEPTH.
- Advance = ~d_valid | ~d_stall.
- Pop = (count != 0) & advance & ~flush. The head at rd_ptr is loaded into the ID slot, and rd_ptr increments modulo DEPTH.
- When advance is true and count == 0 (and there is no flush), d_valid goes to 0. All d_* fields hold their old values.
- A stalled valid slot holds every d_* output unchanged.
- count changes by +1 on push only, −1 on pop only, and is unchanged on both or neither.
- f_ready comes from the current count only. There is no same-cycle pop credit, so when the queue is full a push is refused even if a pop happens in that cycle.
- Flush dominates:
  - count, wr_ptr and rd_ptr are cleared to 0, and d_valid is cleared to 0.
  - A same-cycle push is dropped, and d_stall is ignored.
- Pre-decode is computed from the entry being loaded and registered with it.
  - opcode = instr[31:26]; funct = instr[5:0].
  - add: op 0, funct 0x20. imm 0. rs_tuse 1, rt_tuse 1.
  - sub: op 0, funct 0x22. imm 0. rs_tuse 1, rt_tuse 1.
  - jr: op 0, funct 0x08. imm 0. rs_tuse 0, rt_tuse 3.
  - ori: op 0x0D. imm = zero-extend. rs_tuse 1, rt_tuse 3.
  - lw: op 0x23. imm = sign-extend. rs_tuse 1, rt_tuse 3.
  - sw: op 0x2B. imm = sign-extend. rs_tuse 1, rt_tuse 2.
  - beq: op 0x04. imm = sign-extend(imm16) << 2. rs_tuse 0, rt_tuse 0.
  - lui: op 0x0F. imm = {imm16, 16'b0}. rs_tuse 3, rt_tuse 3.
  - jal: op 0x03. imm 0. rs_tuse 3, rt_tuse 3.
  - Any other encoding: imm 0, rs_tuse 3, rt_tuse 3. The slot is still valid.

## Timing
- Reset values: d_valid 0, all d_* data 0, count 0, pointers 0, queue contents don't-care.
- f_ready is 1 while reset is asserted and after it is released.
- Latency: an instruction pushed at edge N can reach the ID slot at edge N+1 at the earliest. There is no bypass, so minimum fetch-to-d_valid is 2 edges.
- Throughput: one instruction per cycle when the queue is non-empty and the slot is not stalled.
- Boundary cases:
  - Empty + push: count 0→1, no pop that edge.
  - Full: f_ready 0, and the fetch must hold f_pc/f_instr.
  - Pointer wrap: after DEPTH pushes, wr_ptr returns to 0 with no loss.
- If reset is asserted mid-stall or mid-flush, the reset values appear immediately and asynchronously, regardless of the clock.
- flush and d_stall in the same cycle: flush wins.

## Test plan
- Reset, then push lw $8, -4($9) (0x8D28FFFC) at PC 0x3000 → 2 edges later: d_valid 1, d_pc 0x3000, d_rs 9, d_rt 8, d_imm 0xFFFFFFFC, rs_tuse 1, rt_tuse 3.
- Hold d_stall=1 with a valid slot and push 4 instructions (DEPTH=4) → count 4, f_ready 0, fifth f_valid refused, slot unchanged. Release the stall → in-order drain, one instruction per cycle.
- Queue at count 2, assert flush together with f_valid → next edge: count 0, d_valid 0, pushed word lost, f_ready 1.
- beq $1, $2, -1 (0x1022FFFF) → d_imm 0xFFFFFFFC, rs_tuse 0, rt_tuse 0. Then lui $3, 0x1234 → d_imm 0x12340000, both Tuse 3.
- Stream 10 sequential PCs through DEPTH=4 with random d_stall → outputs match input order exactly, wrap exercised, count never exceeds 4.
- Assert reset asynchronously between edges while d_valid=1 and count=3 → d_valid and count go to 0 before the next edge.
